// File: rtl/gray_frame_writer.sv
// Writes one grayscale frame to the SDRAM write port through a first-word-fall-through FIFO.
// Optional macro GRAY_WRITER_BINARY_EN adds i_bw_sel to write pure black/white pixels.
module gray_frame_writer #(
   parameter int unsigned NUM_PIXEL  = 307200,
   parameter int unsigned FIFO_DEPTH = 16,
   parameter int unsigned CNT_W      = 19
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_start,
   input  logic       i_valid,
   input  logic [9:0] i_color,
   input  logic       i_bw,
`ifdef GRAY_WRITER_BINARY_EN
   input  logic       i_bw_sel,
`endif
   input  logic       i_write_ready,
   output logic       o_write_request,
   output logic [9:0] o_red,
   output logic [9:0] o_green,
   output logic [9:0] o_blue,
   output logic       o_done,
   output logic       o_overflow,
   output logic       o_busy
);

   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam logic [CNT_W-1:0] NumPix = CNT_W'(NUM_PIXEL);
`ifdef GRAY_WRITER_BINARY_EN
   localparam int unsigned DW = 11;
`else
   localparam int unsigned DW = 10;
`endif

   typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

   state_e           state_q, state_d;
   logic [DW-1:0]    mem_q [FIFO_DEPTH];
   logic [AW:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] in_cnt_q, in_cnt_d, out_cnt_q, out_cnt_d, drop_cnt_q, drop_cnt_d;
   logic [CNT_W:0]   out_sum;
   logic             overflow_q, overflow_d;
   logic             empty, full, active, pop, run_accept, push_px, push_dummy, drop, wr_en;
   logic [DW-1:0]    wr_data, head;
   logic [9:0]       pix;

   assign empty      = (wr_ptr_q == rd_ptr_q);
   assign full       = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign active     = (state_q == StRun) || (state_q == StDrain);
   assign pop        = active && !empty && i_write_ready;
   assign run_accept = (state_q == StRun) && (in_cnt_q != NumPix);
   assign push_px    = run_accept && i_valid && (!full || pop);
   assign drop       = run_accept && i_valid && full && !pop;
   // Dropped pixels are back-filled with black entries whenever a free slot shows up
   assign push_dummy = run_accept && !i_valid && (drop_cnt_q != '0) && (!full || pop);
   assign wr_en      = push_px || push_dummy;
   assign head       = mem_q[rd_ptr_q[AW-1:0]];

`ifdef GRAY_WRITER_BINARY_EN
   assign wr_data = push_px ? {i_bw, i_color} : {1'b1, 10'd0};
`else
   assign wr_data = push_px ? i_color : 10'd0;
   logic unused_bw;
   assign unused_bw = i_bw;
`endif

   always_comb begin
      pix = '0;
      if (!empty) begin
`ifdef GRAY_WRITER_BINARY_EN
         if (i_bw_sel) begin
            pix = head[10] ? 10'd0 : 10'd1023;
         end else begin
            pix = head[9:0];
         end
`else
         pix = head;
`endif
      end
   end

   always_comb begin
      state_d    = state_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      in_cnt_d   = in_cnt_q;
      drop_cnt_d = drop_cnt_q;
      overflow_d = overflow_q;
      out_sum    = {1'b0, out_cnt_q} + (CNT_W+1)'(pop);
      if (wr_en) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
      if (pop)   rd_ptr_d = rd_ptr_q + (AW+1)'(1);
      if (run_accept && i_valid) in_cnt_d = in_cnt_q + CNT_W'(1);
      if (drop) begin
         drop_cnt_d = drop_cnt_q + CNT_W'(1);
         overflow_d = 1'b1;
      end else if (push_dummy) begin
         drop_cnt_d = drop_cnt_q - CNT_W'(1);
      end
      unique case (state_q)
         StIdle: begin
            if (i_start) begin
               state_d    = StRun;
               wr_ptr_d   = '0;
               rd_ptr_d   = '0;
               in_cnt_d   = '0;
               drop_cnt_d = '0;
               overflow_d = 1'b0;
               out_sum    = '0;
            end
         end
         StRun: begin
            if (in_cnt_q == NumPix) begin
               // Drops never back-filled are credited so out_cnt still reaches the frame size
               state_d    = StDrain;
               out_sum    = out_sum + {1'b0, drop_cnt_q};
               drop_cnt_d = '0;
            end
         end
         StDrain: if (out_cnt_q == NumPix) state_d = StDone;
         StDone:  if (!i_start) state_d = StIdle;
         default: state_d = StIdle;
      endcase
      out_cnt_d = (out_sum > {1'b0, NumPix}) ? NumPix : out_sum[CNT_W-1:0];
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q    <= StIdle;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         in_cnt_q   <= '0;
         out_cnt_q  <= '0;
         drop_cnt_q <= '0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         in_cnt_q   <= in_cnt_d;
         out_cnt_q  <= out_cnt_d;
         drop_cnt_q <= drop_cnt_d;
         overflow_q <= overflow_d;
      end
   end

   always_ff @(posedge i_clk) begin
      if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
   end

   assign o_write_request = active && !empty;
   assign o_red           = pix;
   assign o_green         = pix;
   assign o_blue          = pix;
   assign o_done          = (state_q == StDone);
   assign o_overflow      = overflow_q;
   assign o_busy          = active;

endmodule

// File: tb/tb_gray_frame_writer.sv
// Bench for gray_frame_writer: random and directed frames checked against a queue model.
module tb_gray_frame_writer;

   localparam int N     = 24;
   localparam int DEPTH = 16;

   logic       clk   = 1'b0;
   logic       rst   = 1'b1;
   logic       start = 1'b0;
   logic       valid = 1'b0;
   logic       bw    = 1'b0;
   logic       ready = 1'b0;
   logic [9:0] color = '0;
`ifdef GRAY_WRITER_BINARY_EN
   logic       bw_sel = 1'b0;
`endif
   logic       req, done, ovf_o, busy;
   logic [9:0] red, green, blue;

   int total = 0;
   int bad   = 0;

   // Model: expected FIFO contents as {bw, gray}, frame phase and counters
   int q[$];
   int phase = 0;  // 0 idle, 1 run, 2 drain, 3 done
   int in_n = 0, out_n = 0, pend = 0;
   bit ovf = 1'b0;

   always #5 clk = ~clk;

   gray_frame_writer #(
      .NUM_PIXEL (N),
      .FIFO_DEPTH(DEPTH),
      .CNT_W     (5)
   ) dut (
      .i_clk          (clk),
      .i_rst          (rst),
      .i_start        (start),
      .i_valid        (valid),
      .i_color        (color),
      .i_bw           (bw),
`ifdef GRAY_WRITER_BINARY_EN
      .i_bw_sel       (bw_sel),
`endif
      .i_write_ready  (ready),
      .o_write_request(req),
      .o_red          (red),
      .o_green        (green),
      .o_blue         (blue),
      .o_done         (done),
      .o_overflow     (ovf_o),
      .o_busy         (busy)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic logic [9:0] map(input int e);
`ifdef GRAY_WRITER_BINARY_EN
      if (bw_sel) return e[10] ? 10'd0 : 10'd1023;
`endif
      return e[9:0];
   endfunction

   task automatic check_outputs();
      logic [9:0] d;
      bit         act;
      act = (phase == 1) || (phase == 2);
      d   = (q.size() != 0) ? map(q[0]) : 10'd0;
      chk("write_request", req, act && (q.size() != 0));
      chk("red", red, d);
      chk("green", green, d);
      chk("blue", blue, d);
      chk("busy", busy, act);
      chk("done", done, phase == 3);
      chk("overflow", ovf_o, ovf);
   endtask

   task automatic step(input bit v, input logic [9:0] c, input bit b, input bit r, input bit st);
      bit pop, space;
      @(negedge clk);
      valid = v;
      color = c;
      bw    = b;
      ready = r;
      start = st;
      #1 check_outputs();
      pop = ((phase == 1) || (phase == 2)) && (q.size() != 0) && r;
      case (phase)
         0: begin
            if (st) begin
               phase = 1;
               q.delete();
               in_n  = 0;
               out_n = 0;
               pend  = 0;
               ovf   = 1'b0;
            end
         end
         1: begin
            space = (q.size() < DEPTH) || pop;
            if (pop) begin
               void'(q.pop_front());
               out_n++;
            end
            if (in_n == N) begin
               phase = 2;
               out_n += pend;
               pend  = 0;
            end else if (v) begin
               in_n++;
               if (space) q.push_back({21'd0, b, c});
               else begin
                  pend++;
                  ovf = 1'b1;
               end
            end else if (pend > 0 && space) begin
               q.push_back(1024);
               pend--;
            end
         end
         2: begin
            if (out_n == N) phase = 3;
            if (pop) begin
               void'(q.pop_front());
               out_n++;
            end
         end
         default: if (!st) phase = 0;
      endcase
      if (out_n > N) out_n = N;
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst   = 1'b1;
      valid = 1'b0;
      start = 1'b0;
      ready = 1'b0;
      @(negedge clk);
      rst   = 1'b0;
      phase = 0;
      q.delete();
      in_n  = 0;
      out_n = 0;
      pend  = 0;
      ovf   = 1'b0;
      #1 check_outputs();
   endtask

   task automatic run_frame(input int mode);
      int         c;
      bit         v, r, b;
      logic [9:0] col;
      c = 0;
      while (phase != 3 && c < 2000) begin
         col = 10'($urandom_range(0, 1023));
         b   = 1'($urandom_range(0, 1));
         v   = 1'b1;
         r   = 1'b1;
         case (mode)
            0: col = 10'(in_n);
            1: begin
               v = (in_n < 12) || ($urandom_range(0, 1) == 1);
               r = !(c >= 2 && c < 12);
            end
            2: begin
               v = (in_n < 20) || ($urandom_range(0, 1) == 1);
               r = (in_n >= 20);
            end
            3: begin
               v = 1'($urandom_range(0, 1));
               r = ($urandom_range(0, 2) == 0);
            end
            4: r = (in_n >= 16);
            5: begin
               if (in_n == 0) begin
                  col = 10'd500;
                  b   = 1'b1;
               end else if (in_n == 1) begin
                  col = 10'd200;
                  b   = 1'b0;
               end
            end
            default: ;
         endcase
         step(v, col, b, r, 1'b1);
         c++;
      end
      chk("frame_within_budget", c < 2000, 1'b1);
      step(1'b1, 10'd5, 1'b0, 1'b1, 1'b1);
      if (mode == 0 || mode == 4) chk("no_overflow", ovf_o, 1'b0);
      if (mode == 2) chk("overflow_seen", ovf_o, 1'b1);
      for (int i = 0; i < 3; i++) step(1'b0, 10'd0, 1'b0, 1'b1, 1'b0);
   endtask

   initial begin
      apply_reset();
      run_frame(0);
      run_frame(1);
      run_frame(2);
      run_frame(4);
      run_frame(3);
      run_frame(3);
      // Reset while three pixels sit in the FIFO
      step(1'b0, 10'd0, 1'b0, 1'b0, 1'b1);
      for (int k = 0; k < 3; k++) step(1'b1, 10'(k + 1), 1'b0, 1'b0, 1'b1);
      apply_reset();
      run_frame(0);
`ifdef GRAY_WRITER_BINARY_EN
      bw_sel = 1'b1;
      run_frame(5);
      run_frame(3);
      bw_sel = 1'b0;
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
